// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter: phase/sub-phase enums,
// pin bundle, RMW byte merge and the phase-sequencing rule.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } wr_sub_t;

  typedef struct packed {
    logic cs_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } pins_t;

  localparam pins_t PINS_IDLE = '{cs_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

  function automatic logic [15:0] merge16(input logic [15:0] old_d, input logic [15:0] new_d,
                                          input logic [1:0] strb2);
    merge16 = {(strb2[1] ? new_d[15:8] : old_d[15:8]), (strb2[0] ? new_d[7:0] : old_d[7:0])};
  endfunction

  // Bit i set when the phase encoded as state value i+1 must run for this strobe set.
  function automatic logic [3:0] phase_need(input logic [3:0] wstrb);
    logic rd_all;
    rd_all        = (wstrb == 4'b0000);
    phase_need[0] = rd_all || (wstrb[1] ^ wstrb[0]);
    phase_need[1] = |wstrb[1:0];
    phase_need[2] = rd_all || (wstrb[3] ^ wstrb[2]);
    phase_need[3] = |wstrb[3:2];
  endfunction

  function automatic state_t next_phase(input state_t cur, input logic [3:0] wstrb);
    logic [3:0] need;
    need       = phase_need(wstrb);
    next_phase = DONE;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(cur)) && need[i]) begin
        next_phase = state_t'(3'(i + 1));
      end
    end
  endfunction

  function automatic pins_t pins_for(input state_t st, input wr_sub_t sub);
    pins_for = PINS_IDLE;
    case (st)
      RD_LO, RD_HI: begin
        pins_for.cs_n = 1'b0;
        pins_for.oe_n = 1'b0;
      end
      WR_LO, WR_HI: begin
        pins_for.cs_n  = 1'b0;
        pins_for.we_n  = (sub == PULSE) ? 1'b0 : 1'b1;
        pins_for.dq_oe = 1'b1;
      end
      default: pins_for = PINS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not granted last. last_grant resets to 1 so port 0 wins the first tie.
module sram_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_last_grant;

  // Grant decision from current requests and the last winner.
  always_comb begin
    o_gnt_valid = |i_req;
    if (i_req == 2'b11) begin
      o_gnt_id = ~r_last_grant;
    end else if (i_req[1]) begin
      o_gnt_id = 1'b1;
    end else begin
      o_gnt_id = 1'b0;
    end
  end

  // Remember the winner whenever a grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 1'b1;
    end else if (i_accept && o_gnt_valid) begin
      r_last_grant <= o_gnt_id;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Shares one 256Kx16 async SRAM between two 32-bit requesters; each word access is
// split into low/high half-word phases, with read-modify-write for partial strobes.
module sram_arbiter_ctrl
  import sram_arb_pkg::*;
#(
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_valid,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_wstrb,
  output logic        o_p0_ready,
  output logic [31:0] o_p0_rdata,
  input  logic        i_p1_valid,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_wstrb,
  output logic        o_p1_ready,
  output logic [31:0] o_p1_rdata,
  output logic [17:0] o_sram_addr,
  input  logic [15:0] i_sram_dq_i,
  output logic [15:0] o_sram_dq_o,
  output logic        o_sram_dq_oe,
  output logic        o_sram_cs_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
  localparam logic [7:0] WE_LAST = 8'(WE_CYCLES - 1);

  state_t      r_state;
  wr_sub_t     r_sub;
  logic [7:0]  r_cnt;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_port;
  logic [31:0] r_rdata;
  logic        r_p0_ready;
  logic        r_p1_ready;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;
  logic [17:0] r_sram_addr;
  pins_t       r_pins;
  logic [15:0] r_dq_o;

  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic        w_phase_end;
  logic        w_advance;
  state_t      w_target;
  logic [16:0] w_word;
  logic [31:0] w_wdata;
  logic [3:0]  w_strb;
  logic        w_half;
  logic [15:0] w_dq_next;
  logic [31:0] w_rd_word;
  logic        w_unused_addr_bits;

  assign w_unused_addr_bits = ^{i_p0_addr[31:19], i_p0_addr[1:0], i_p1_addr[31:19], i_p1_addr[1:0]};

  sram_rr_arb2 u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       ({i_p1_valid, i_p0_valid}),
    .i_accept    (r_state == IDLE),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // Phase-end detection, next phase selection and the data for the phase being entered.
  always_comb begin
    case (r_state)
      RD_LO, RD_HI: w_phase_end = (r_cnt == RD_LAST);
      WR_LO, WR_HI: w_phase_end = (r_sub == HOLD);
      default:      w_phase_end = 1'b0;
    endcase
    if (r_state == IDLE) begin
      w_advance = w_gnt_valid;
      w_word    = w_gnt_id ? i_p1_addr[18:2] : i_p0_addr[18:2];
      w_wdata   = w_gnt_id ? i_p1_wdata : i_p0_wdata;
      w_strb    = w_gnt_id ? i_p1_wstrb : i_p0_wstrb;
    end else begin
      w_advance = w_phase_end;
      w_word    = r_word;
      w_wdata   = r_wdata;
      w_strb    = r_wstrb;
    end
    w_target  = next_phase(r_state, w_strb);
    w_half    = (w_target == RD_HI) || (w_target == WR_HI);
    // On entry to WR_h the read-back of RD_h is still on the bus this clock.
    w_dq_next = w_half ? merge16(i_sram_dq_i, w_wdata[31:16], w_strb[3:2])
                       : merge16(i_sram_dq_i, w_wdata[15:0], w_strb[1:0]);
    w_rd_word = {((r_state == RD_HI) ? i_sram_dq_i : r_rdata[31:16]), r_rdata[15:0]};
  end

  // Sequencing FSM with registered SRAM pins and port responses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_sub       <= SETUP;
      r_cnt       <= 8'd0;
      r_word      <= 17'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_port      <= 1'b0;
      r_rdata     <= 32'd0;
      r_p0_ready  <= 1'b0;
      r_p1_ready  <= 1'b0;
      r_p0_rdata  <= 32'd0;
      r_p1_rdata  <= 32'd0;
      r_sram_addr <= 18'd0;
      r_pins      <= PINS_IDLE;
      r_dq_o      <= 16'd0;
    end else begin
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;
      if ((r_state == RD_LO) && w_phase_end) begin
        r_rdata[15:0] <= i_sram_dq_i;
      end else if ((r_state == RD_HI) && w_phase_end) begin
        r_rdata[31:16] <= i_sram_dq_i;
      end else if ((r_state == IDLE) && w_gnt_valid) begin
        r_rdata <= 32'd0;
      end

      if (w_advance) begin
        if (r_state == IDLE) begin
          r_word  <= w_word;
          r_wdata <= w_wdata;
          r_wstrb <= w_strb;
          r_port  <= w_gnt_id;
        end
        r_state <= w_target;
        r_sub   <= SETUP;
        r_cnt   <= 8'd0;
        r_pins  <= pins_for(w_target, SETUP);
        if (w_target == DONE) begin
          r_p0_ready <= ~r_port;
          r_p1_ready <= r_port;
          if (r_port) begin
            r_p1_rdata <= w_rd_word;
          end else begin
            r_p0_rdata <= w_rd_word;
          end
        end else begin
          r_sram_addr <= {w_word, w_half};
          r_dq_o      <= w_dq_next;
        end
      end else begin
        case (r_state)
          RD_LO, RD_HI: r_cnt <= r_cnt + 8'd1;
          WR_LO, WR_HI: begin
            case (r_sub)
              SETUP: begin
                r_sub       <= PULSE;
                r_cnt       <= 8'd0;
                r_pins.we_n <= 1'b0;
              end
              PULSE: begin
                if (r_cnt == WE_LAST) begin
                  r_sub       <= HOLD;
                  r_pins.we_n <= 1'b1;
                end else begin
                  r_cnt <= r_cnt + 8'd1;
                end
              end
              default: r_sub <= r_sub;
            endcase
          end
          DONE: begin
            r_state <= IDLE;
            r_pins  <= PINS_IDLE;
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_p0_ready   = r_p0_ready;
  assign o_p1_ready   = r_p1_ready;
  assign o_p0_rdata   = r_p0_rdata;
  assign o_p1_rdata   = r_p1_rdata;
  assign o_sram_addr  = r_sram_addr;
  assign o_sram_dq_o  = r_dq_o;
  assign o_sram_dq_oe = r_pins.dq_oe;
  assign o_sram_cs_n  = r_pins.cs_n;
  assign o_sram_oe_n  = r_pins.oe_n;
  assign o_sram_we_n  = r_pins.we_n;

endmodule
